rib_rr: RTL and testbench

RIB_RR -- requirements
Module: rib_rr

---
 rtl/rib_rr_pkg.sv | 19 +
 rtl/rib_rr_rr_sel.sv | 29 ++
 rtl/rib_rr.sv | 150 +++++++++++++++
 tb/tb_rib_rr.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rib_rr_pkg.sv
// rib_rr_pkg: shared word constants and FSM state type for the rib_rr bus arbiter.
`ifndef RIB_RR_DEFINES
`define RIB_RR_DEFINES
`define INST_NOP    32'h00000013
`define ZeroWord    32'h00000000
`define HoldEnable  1'b1
`define HoldDisable 1'b0
`endif

package rib_rr_pkg;

    localparam logic [31:0] INST_NOP     = `INST_NOP;
    localparam logic [31:0] ZERO_WORD    = `ZeroWord;
    localparam logic        HOLD_ENABLE  = `HoldEnable;
    localparam logic        HOLD_DISABLE = `HoldDisable;

    typedef enum logic {IDLE, OWN} state_e;

endpackage

// File: rtl/rib_rr_rr_sel.sv
// rib_rr_rr_sel: combinational round-robin picker, searching upward from ptr_i+1 modulo NM.
module rib_rr_rr_sel #(
    parameter int NM = 5,
    parameter int OW = 3
) (
    input  logic [NM-1:0] req_i,
    input  logic [NM-1:0] excl_i,
    input  logic [OW-1:0] ptr_i,
    output logic [OW-1:0] idx_o,
    output logic          vld_o
);

    logic [OW-1:0] j;

    // Scan farthest-first so the last hit is the one closest after the pointer.
    always_comb begin
        idx_o = '0;
        vld_o = 1'b0;
        j     = '0;
        for (int i = NM; i >= 1; i--) begin
            j = OW'((int'(ptr_i) + i) % NM);
            if (req_i[j] && !excl_i[j]) begin
                idx_o = j;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rib_rr.sv
// rib_rr: NM-master / NS-slave bus arbiter with a priority master, round-robin rotation,
// bounded ownership and combinational address-decoded routing.
module rib_rr
    import rib_rr_pkg::*;
#(
    parameter int              NM           = 5,
    parameter int              NS           = 3,
    parameter logic [NS*4-1:0] SLV_MAP      = {4'h3, 4'h1, 4'h0},
    parameter int              HP_MASTER    = 3,
    parameter int              FETCH_MASTER = 1,
    parameter int              MAX_HOLD     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NM*32-1:0] m_addr_i,
    input  logic [NM*32-1:0] m_data_i,
    input  logic [NM-1:0]    m_req_i,
    input  logic [NM-1:0]    m_we_i,
    input  logic [NM-1:0]    m_lock_i,
    output logic [NM*32-1:0] m_data_o,
    output logic [NM-1:0]    m_gnt_o,
    output logic [NM-1:0]    m_err_o,
    output logic [NS*32-1:0] s_addr_o,
    output logic [NS*32-1:0] s_data_o,
    output logic [NS-1:0]    s_we_o,
    input  logic [NS*32-1:0] s_data_i,
    output logic             hold_flag_o
);

    localparam int             OW         = $clog2(NM);
    localparam int             HW         = $clog2(MAX_HOLD + 1);
    localparam logic [OW-1:0]  HP         = OW'(HP_MASTER);
    localparam logic [HW-1:0]  HOLD_MAX   = HW'(MAX_HOLD - 1);
    localparam logic [NM-1:0]  FETCH_MASK = NM'(1) << FETCH_MASTER;

    state_e        state_q, state_d;
    logic [OW-1:0] owner_q, owner_d;
    logic [OW-1:0] rr_ptr_q, rr_ptr_d;
    logic [HW-1:0] hold_q, hold_d;

    logic [NM-1:0] own;
    logic [31:0]   sel_addr, sel_data, rdata;
    logic          sel_we, own_req, own_lock, owner_hp, hp_cand, leave, hit;
    logic [OW-1:0] sel_ptr, sel_idx, win;
    logic          sel_vld, win_vld;

    always_comb begin
        own      = '0;
        sel_addr = ZERO_WORD;
        sel_data = ZERO_WORD;
        sel_we   = 1'b0;
        for (int i = 0; i < NM; i++) begin
            own[i] = (state_q == OWN) && (owner_q == OW'(i));
            if (own[i]) begin
                sel_addr = m_addr_i[32*i +: 32];
                sel_data = m_data_i[32*i +: 32];
                sel_we   = m_we_i[i];
            end
        end
    end

    assign own_req  = |(own & m_req_i);
    assign own_lock = |(own & m_lock_i);
    assign owner_hp = owner_q == HP;
    assign hp_cand  = m_req_i[HP_MASTER] && !own[HP_MASTER];
    // A priority owner never becomes the round-robin reference point.
    assign sel_ptr  = (state_q == OWN && !owner_hp) ? owner_q : rr_ptr_q;
    assign win      = hp_cand ? HP : sel_idx;
    assign win_vld  = hp_cand || sel_vld;
    assign leave    = !own_req ||
                      (!own_lock && ((hold_q == HOLD_MAX && |(m_req_i & ~own)) || hp_cand));

    rib_rr_rr_sel #(
        .NM(NM),
        .OW(OW)
    ) u_rr_sel (
        .req_i (m_req_i),
        .excl_i(own),
        .ptr_i (sel_ptr),
        .idx_o (sel_idx),
        .vld_o (sel_vld)
    );

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        hold_d   = hold_q;
        if (state_q == IDLE) begin
            if (win_vld) begin
                state_d = OWN;
                owner_d = win;
                hold_d  = '0;
            end
        end else if (leave) begin
            rr_ptr_d = owner_hp ? rr_ptr_q : owner_q;
            state_d  = win_vld ? OWN : IDLE;
            owner_d  = win_vld ? win : owner_q;
            hold_d   = '0;
        end else begin
            hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= OW'(NM - 1);
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // First matching SLV_MAP entry wins, so at most one slave is ever selected.
    always_comb begin
        s_addr_o = '0;
        s_data_o = '0;
        s_we_o   = '0;
        rdata    = ZERO_WORD;
        hit      = 1'b0;
        for (int k = 0; k < NS; k++) begin
            if (state_q == OWN && !hit && sel_addr[31:28] == SLV_MAP[4*k +: 4]) begin
                hit                  = 1'b1;
                s_addr_o[32*k +: 32] = {4'h0, sel_addr[27:0]};
                s_data_o[32*k +: 32] = sel_data;
                s_we_o[k]            = sel_we;
                rdata                = s_data_i[32*k +: 32];
            end
        end
    end

    always_comb begin
        m_gnt_o  = '0;
        m_err_o  = '0;
        m_data_o = '0;
        for (int i = 0; i < NM; i++) begin
            m_gnt_o[i]           = own[i];
            m_err_o[i]           = own[i] && !hit;
            m_data_o[32*i +: 32] = own[i] ? rdata : (i == FETCH_MASTER ? INST_NOP : ZERO_WORD);
        end
    end

    assign hold_flag_o = |(m_req_i & ~FETCH_MASK) ? HOLD_ENABLE : HOLD_DISABLE;

endmodule

// File: tb/tb_rib_rr.sv
// tb_rib_rr: scoreboard bench for rib_rr covering reset, routing, rotation, preemption,
// decode errors, fetch NOP, hold flag and asynchronous reset abort.
module tb_rib_rr;
    import rib_rr_pkg::*;

    localparam int NM = 5;
    localparam int NS = 3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NM*32-1:0] m_addr_i, m_data_i, m_data_o;
    logic [NM-1:0]    m_req_i, m_we_i, m_lock_i, m_gnt_o, m_err_o;
    logic [NS*32-1:0] s_addr_o, s_data_o, s_data_i;
    logic [NS-1:0]    s_we_o;
    logic             hold_flag_o;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    rib_rr dut (
        .clk        (clk),
        .rst        (rst),
        .m_addr_i   (m_addr_i),
        .m_data_i   (m_data_i),
        .m_req_i    (m_req_i),
        .m_we_i     (m_we_i),
        .m_lock_i   (m_lock_i),
        .m_data_o   (m_data_o),
        .m_gnt_o    (m_gnt_o),
        .m_err_o    (m_err_o),
        .s_addr_o   (s_addr_o),
        .s_data_o   (s_data_o),
        .s_we_o     (s_we_o),
        .s_data_i   (s_data_i),
        .hold_flag_o(hold_flag_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop(input logic [31:0] got);
        exp_t e;
        if (sb.size() == 0) chk("sb_underflow", 32'(sb.size()), 1);
        else begin
            e = sb.pop_front();
            chk(e.tag, got, e.val);
        end
    endtask

    task automatic drv(input int i, input logic req, input logic we, input logic lock,
                       input logic [31:0] a, input logic [31:0] d);
        m_req_i[i]           = req;
        m_we_i[i]            = we;
        m_lock_i[i]          = lock;
        m_addr_i[32*i +: 32] = a;
        m_data_i[32*i +: 32] = d;
    endtask

    task automatic clr();
        m_req_i  = '0;
        m_we_i   = '0;
        m_lock_i = '0;
        m_addr_i = '0;
        m_data_i = '0;
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic sm();
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        nx();
        nx();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] md(input int i);
        return m_data_o[32*i +: 32];
    endfunction

    function automatic logic [31:0] sa(input int k);
        return s_addr_o[32*k +: 32];
    endfunction

    function automatic logic [31:0] sd(input int k);
        return s_data_o[32*k +: 32];
    endfunction

    function automatic int gidx(input logic [NM-1:0] g);
        for (int i = 0; i < NM; i++) if (g[i]) return i;
        return -1;
    endfunction

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

    initial begin
        int prev, cur, run, seen;
        clr();
        s_data_i = {32'hA000_0002, 32'hA000_0001, 32'hA000_0000};
        rst = 1'b1;
        repeat (2) @(posedge clk);
        sm();
        chk("rst_gnt", 32'(m_gnt_o), 0);
        chk("rst_we", 32'(s_we_o), 0);
        chk("rst_err", 32'(m_err_o), 0);
        chk("rst_saddr", 32'(|s_addr_o), 0);
        chk("rst_sdata", 32'(|s_data_o), 0);
        chk("rst_fetch_nop", md(1), INST_NOP);
        chk("rst_md0", md(0), 0);
        nx();
        rst = 1'b0;

        // m0 read to slave 1, granted one cycle after the request
        drv(0, 1, 0, 0, 32'h1000_0010, 32'h0);
        push("gnt_before_edge", 0);
        sm();
        pop(32'(m_gnt_o));
        push("gnt_m0", 32'h01);
        push("saddr1", 32'h0000_0010);
        push("md0_from_s1", 32'hA000_0001);
        push("fetch_nop_m1", INST_NOP);
        nx();
        sm();
        pop(32'(m_gnt_o));
        pop(sa(1));
        pop(md(0));
        pop(md(1));
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        push("gnt_idle", 0);
        nx();
        sm();
        pop(32'(m_gnt_o));

        // m0, m2, m4 rotate every MAX_HOLD cycles
        do_reset();
        drv(0, 1, 0, 0, 32'h0, 32'h0);
        drv(2, 1, 0, 0, 32'h0, 32'h0);
        drv(4, 1, 0, 0, 32'h0, 32'h0);
        push("rot_owner", 0); push("rot_len", 8);
        push("rot_owner", 2); push("rot_len", 8);
        push("rot_owner", 4); push("rot_len", 8);
        push("rot_owner", 0);
        prev = -1;
        run  = 0;
        seen = 0;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            sm();
            chk("onehot_gnt", 32'($countones(m_gnt_o) <= 1), 1);
            cur = gidx(m_gnt_o);
            if (cur != prev) begin
                if (prev >= 0) pop(32'(run));
                if (cur >= 0) begin
                    pop(32'(cur));
                    seen++;
                end
                prev = cur;
                run  = 1;
            end else run++;
            nx();
        end

        // unlocked m0 preempted by m3 at the next edge
        do_reset();
        drv(0, 1, 0, 0, 32'h0, 32'h0);
        nx();
        nx();
        nx();
        drv(3, 1, 0, 0, 32'h0000_0008, 32'h0);
        push("pre_preempt", 32'h01);
        push("preempt_m3", 32'h08);
        sm();
        pop(32'(m_gnt_o));
        nx();
        sm();
        pop(32'(m_gnt_o));

        // locked m0 keeps ownership past MAX_HOLD until it releases
        do_reset();
        drv(0, 1, 0, 1, 32'h0, 32'h0);
        nx();
        drv(3, 1, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < 10; c++) begin
            push("lock_hold", 32'h01);
            sm();
            pop(32'(m_gnt_o));
            nx();
        end
        drv(0, 0, 0, 0, 32'h0, 32'h0);
        push("lock_last", 32'h01);
        push("hp_after_release", 32'h08);
        sm();
        pop(32'(m_gnt_o));
        nx();
        sm();
        pop(32'(m_gnt_o));
        // pointer still refers to m0, not the priority master
        nx();
        drv(1, 1, 0, 0, 32'h0, 32'h0);
        drv(4, 1, 0, 0, 32'h0, 32'h0);
        drv(3, 0, 0, 0, 32'h0, 32'h0);
        push("rr_after_hp", 32'h02);
        nx();
        sm();
        pop(32'(m_gnt_o));

        // decode miss
        do_reset();
        drv(2, 1, 1, 0, 32'h5000_0000, 32'h1234_5678);
        push("err_pre", 0);
        sm();
        pop(32'(m_err_o));
        push("err_m2", 32'h04);
        push("err_we", 0);
        push("err_md2", 0);
        push("err_gnt", 32'h04);
        nx();
        sm();
        pop(32'(m_err_o));
        pop(32'(s_we_o));
        pop(md(2));
        pop(32'(m_gnt_o));
        nx();
        drv(2, 0, 0, 0, 32'h0, 32'h0);
        push("err_clear", 0);
        nx();
        sm();
        pop(32'(m_err_o));

        // fetch NOP and hold flag
        do_reset();
        sm();
        chk("idle_fetch_nop", md(1), INST_NOP);
        chk("idle_hold", 32'(hold_flag_o), 0);
        nx();
        drv(1, 1, 0, 0, 32'h0000_0040, 32'h0);
        push("hold_fetch_only", 0);
        sm();
        pop(32'(hold_flag_o));
        push("fetch_read", 32'hA000_0000);
        nx();
        sm();
        pop(md(1));
        nx();
        drv(4, 1, 0, 0, 32'h0, 32'h0);
        push("hold_m4", 1);
        #1;
        pop(32'(hold_flag_o));

        // asynchronous reset aborts an m0 write
        do_reset();
        drv(0, 1, 1, 0, 32'h0000_0004, 32'hDEAD_BEEF);
        push("wr_we", 32'h01);
        push("wr_saddr0", 32'h0000_0004);
        push("wr_sdata0", 32'hDEAD_BEEF);
        nx();
        sm();
        pop(32'(s_we_o));
        pop(sa(0));
        pop(sd(0));
        #1;
        rst = 1'b1;
        #1;
        chk("async_we", 32'(s_we_o), 0);
        chk("async_gnt", 32'(m_gnt_o), 0);
        chk("async_saddr", 32'(|s_addr_o), 0);
        nx();
        rst = 1'b0;
        clr();
        drv(0, 1, 0, 0, 32'h0000_0004, 32'h0);
        drv(2, 1, 0, 0, 32'h1000_0000, 32'h0);
        push("post_rst_we", 0);
        sm();
        pop(32'(s_we_o));
        push("post_rst_gnt", 32'h01);
        nx();
        sm();
        pop(32'(m_gnt_o));

        chk("sb_drain", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
